// File: rtl/pulse_hs_pkg.sv
// ----------------------------------------------------------------------------
// pulse_hs_pkg : state encoding and limits shared by the pulse handshake ends
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pulse_hs_pkg;

  localparam logic ST_IDLE     = 1'b0;
  localparam logic ST_WAIT_ACK = 1'b1;

  localparam int unsigned SYNC_STAGES_MIN = 2;

  typedef enum logic {
    IDLE     = ST_IDLE,
    WAIT_ACK = ST_WAIT_ACK
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// ----------------------------------------------------------------------------
// bit_sync : STAGES-deep single-bit resynchroniser, synchronous reset to 0
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bit_sync
  import pulse_hs_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  localparam int unsigned DEPTH = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/pulse_hs_tx.sv
// ----------------------------------------------------------------------------
// pulse_hs_tx : initiator side of a two-phase req/ack pulse handshake
// Optional watchdog: define PULSE_HS_TX_TIMEOUT_EN.            rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pulse_hs_tx
  import pulse_hs_pkg::*;
#(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack_toggle_async,
  output logic             req_toggle,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             pulse_done,
  output logic             overflow,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             ack_seen_q;
  logic             ack_sync;
  logic             ack_edge;
  logic             ack_acc;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ack_toggle_async),
    .q_o (ack_sync)
  );

  assign ack_edge = ack_sync ^ ack_seen_q;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    done_d    = 1'b0;
    ack_acc   = 1'b0;
    pending_d = pending_q;
    ovf_d     = ovf_q;

    // An ack edge seen in IDLE is stale (peer reset skew) and is dropped.
    case (state_q)
      IDLE: begin
        if (pending_q != '0) begin
          req_d   = ~req_q;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_edge) begin
          ack_acc = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pulse_in && !ack_acc) begin
      if (pending_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + CNT_W'(1);
      end
    end else if (!pulse_in && ack_acc) begin
      pending_d = pending_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ack_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      req_q      <= req_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      ack_seen_q <= ack_sync;
    end
  end

`ifdef PULSE_HS_TX_TIMEOUT_EN
  localparam int unsigned      WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT_CYC);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;

  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (state_q == IDLE && state_d == WAIT_ACK) begin
      wd_d = '0;
    end else if (state_q == WAIT_ACK && wd_q != WD_MAX) begin
      wd_d = wd_q + WD_W'(1);
      if (wd_d == WD_MAX) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  assign req_toggle = req_q;
  assign pending    = pending_q;
  assign busy       = (state_q == WAIT_ACK);
  assign pulse_done = done_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_hs_tx.sv
// ----------------------------------------------------------------------------
// tb_pulse_hs_tx : two instances (CNT_W=4 and CNT_W=2) against a reference model
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pulse_hs_tx;

  localparam int SYNC = 2;
  localparam int TCYC = 16;
`ifdef PULSE_HS_TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse_v [2];
  logic ack_v   [2];

  logic       req_a, busy_a, done_a, ovf_a, to_a;
  logic [3:0] pend_a;
  logic       req_b, busy_b, done_b, ovf_b, to_b;
  logic [1:0] pend_b;

  always #5 clk = ~clk;

  pulse_hs_tx #(.CNT_W(4), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TCYC)) u_dut_a (
    .clk(clk), .rst(rst), .pulse_in(pulse_v[0]), .ack_toggle_async(ack_v[0]),
    .req_toggle(req_a), .pending(pend_a), .busy(busy_a), .pulse_done(done_a),
    .overflow(ovf_a), .timeout(to_a)
  );

  pulse_hs_tx #(.CNT_W(2), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TCYC)) u_dut_b (
    .clk(clk), .rst(rst), .pulse_in(pulse_v[1]), .ack_toggle_async(ack_v[1]),
    .req_toggle(req_b), .pending(pend_b), .busy(busy_b), .pulse_done(done_b),
    .overflow(ovf_b), .timeout(to_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: event count as an integer, ack seen SYNC edges late.
  int cap   [2] = '{15, 3};
  int m_pend[2];
  int m_wd  [2];
  bit m_req [2], m_inf[2], m_done[2], m_ovf[2], m_to[2], m_seen[2];
  bit m_sh  [2][SYNC];

  // Destination-side responder.
  bit resp_en  [2];
  bit resp_last[2];
  bit resp_rand;
  int resp_dly [2];
  int resp_cnt [2];
  int ack_flip_cyc[2];

  int flips_a, dones_a, peak_a;
  bit prev_req_a;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int i);
    if (i == 0) return {19'b0, req_a, busy_a, done_a, ovf_a, to_a, 4'b0, pend_a};
    return {19'b0, req_b, busy_b, done_b, ovf_b, to_b, 6'b0, pend_b};
  endfunction

  function automatic logic [31:0] expw(input int i);
    return {19'b0, m_req[i], m_inf[i], m_done[i], m_ovf[i], m_to[i], 8'(m_pend[i])};
  endfunction

  function automatic bit accept_next(input int i);
    return m_inf[i] && (m_sh[i][SYNC-1] ^ m_seen[i]);
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pend[i] = 0; m_wd[i] = 0; m_req[i] = 0; m_inf[i] = 0; m_done[i] = 0;
        m_ovf[i] = 0; m_to[i] = 0; m_seen[i] = 0;
        for (int k = 0; k < SYNC; k++) m_sh[i][k] = 0;
      end else begin
        bit sync_old, acc, launch;
        sync_old = m_sh[i][SYNC-1];
        acc      = m_inf[i] && (sync_old ^ m_seen[i]);
        launch   = !m_inf[i] && (m_pend[i] != 0);
        if (pulse_v[i] && !acc) begin
          if (m_pend[i] == cap[i]) m_ovf[i] = 1;
          else m_pend[i]++;
        end else if (!pulse_v[i] && acc) begin
          m_pend[i]--;
        end
        if (TO_EN) begin
          if (launch) m_wd[i] = 0;
          else if (m_inf[i] && m_wd[i] < TCYC) begin
            m_wd[i]++;
            if (m_wd[i] == TCYC) m_to[i] = 1;
          end
        end
        m_done[i] = acc;
        if (launch) begin m_req[i] = ~m_req[i]; m_inf[i] = 1; end
        if (acc) m_inf[i] = 0;
        m_seen[i] = sync_old;
        for (int k = SYNC-1; k > 0; k--) m_sh[i][k] = m_sh[i][k-1];
        m_sh[i][0] = ack_v[i];
      end
    end
  endtask

  task automatic respond();
    for (int i = 0; i < 2; i++) begin
      if (resp_en[i] && m_req[i] != resp_last[i]) begin
        resp_last[i] = m_req[i];
        resp_cnt[i]  = (resp_rand ? int'($urandom_range(0, 6)) : resp_dly[i]) + 1;
      end
      if (resp_cnt[i] > 0) begin
        resp_cnt[i]--;
        if (resp_cnt[i] == 0) begin
          ack_v[i]        = ~ack_v[i];
          ack_flip_cyc[i] = cyc;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    check_eq("inst_a", obs(0), expw(0));
    check_eq("inst_b", obs(1), expw(1));
    if (req_a !== prev_req_a) flips_a++;
    prev_req_a = req_a;
    if (done_a === 1'b1) dones_a++;
    if (int'(pend_a) > peak_a) peak_a = int'(pend_a);
    respond();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pulse_v[i] = 0; ack_v[i] = 0; resp_last[i] = 0; resp_cnt[i] = 0;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n = 0;
    while ((m_inf[i] || m_pend[i] != 0) && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pulse_v[i] = 0; ack_v[i] = 0; resp_en[i] = 1; resp_dly[i] = 3;
    end
    resp_rand  = 0;
    prev_req_a = 0;
    do_reset();
    check_eq("reset_a", obs(0), 32'd0);
    check_eq("reset_b", obs(1), 32'd0);

    // Single event with a 5-cycle ack delay.
    resp_dly[0] = 5;
    pulse_v[0] = 1; tick(); pulse_v[0] = 0;
    check_eq("single_pend1", 32'(pend_a), 32'd1);
    check_eq("single_req_before", 32'(req_a), 32'd0);
    tick();
    check_eq("single_req_flip", 32'(req_a), 32'd1);
    begin
      int n = 0;
      while (done_a !== 1'b1 && n < 40) begin tick(); n++; end
      check_eq("single_done_seen", 32'(done_a), 32'd1);
      check_eq("single_done_lat", 32'(cyc - ack_flip_cyc[0]), 32'(SYNC + 1));
    end
    tick();
    check_eq("single_pend0", 32'(pend_a), 32'd0);
    check_eq("single_busy0", 32'(busy_a), 32'd0);

    // Burst of 5 with 3-cycle ack delay.
    resp_dly[0] = 3;
    flips_a = 0; dones_a = 0; peak_a = 0;
    for (int k = 0; k < 5; k++) begin pulse_v[0] = 1; tick(); end
    pulse_v[0] = 0;
    wait_idle(0, 200);
    tick();
    check_eq("burst_flips", 32'(flips_a), 32'd5);
    check_eq("burst_dones", 32'(dones_a), 32'd5);
    check_eq("burst_peak", 32'(peak_a), 32'd5);
    check_eq("burst_ovf", 32'(ovf_a), 32'd0);

    // Overflow on the 2-bit counter, acks withheld.
    resp_en[1] = 0;
    for (int k = 0; k < 4; k++) begin pulse_v[1] = 1; tick(); end
    pulse_v[1] = 0;
    check_eq("ovf_pend_sat", 32'(pend_b), 32'd3);
    check_eq("ovf_flag", 32'(ovf_b), 32'd1);
    resp_en[1] = 1;
    wait_idle(1, 200);
    check_eq("ovf_drained", 32'(pend_b), 32'd0);
    check_eq("ovf_sticky", 32'(ovf_b), 32'd1);

    // Pulse in the very cycle an ack is accepted, with 2 pending.
    resp_dly[0] = 4;
    pulse_v[0] = 1; tick(); tick(); pulse_v[0] = 0;
    begin
      int n = 0;
      while (!accept_next(0) && n < 40) begin tick(); n++; end
      check_eq("simul_reached", 32'(n < 40), 32'd1);
    end
    check_eq("simul_pend_before", 32'(pend_a), 32'd2);
    pulse_v[0] = 1; tick(); pulse_v[0] = 0;
    check_eq("simul_pend", 32'(pend_a), 32'd2);
    check_eq("simul_done", 32'(done_a), 32'd1);
    wait_idle(0, 200);

    // Spurious ack toggle while idle.
    flips_a = 0; dones_a = 0;
    ack_v[0] = ~ack_v[0];
    repeat (6) tick();
    check_eq("spur_flips", 32'(flips_a), 32'd0);
    check_eq("spur_dones", 32'(dones_a), 32'd0);

    // Reset during WAIT_ACK.
    resp_en[0] = 0;
    pulse_v[0] = 1; tick(); pulse_v[0] = 0; tick(); tick();
    check_eq("pre_rst_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin ack_v[i] = 0; resp_last[i] = 0; resp_cnt[i] = 0; end
    tick();
    check_eq("rst_mid_a", obs(0), 32'd0);
    check_eq("rst_mid_b", obs(1), 32'd0);
    rst = 1'b0;
    tick();
    resp_en[0] = 1;

`ifdef PULSE_HS_TX_TIMEOUT_EN
    // Watchdog: never ack, then ack late.
    resp_en[0] = 0;
    pulse_v[0] = 1; tick(); pulse_v[0] = 0;
    tick();
    for (int k = 1; k <= TCYC; k++) begin
      tick();
      check_eq("wd_timeout", 32'(to_a), 32'(k == TCYC));
    end
    resp_en[0] = 1;
    dones_a = 0;
    wait_idle(0, 100);
    tick();
    check_eq("wd_late_done", 32'(dones_a), 32'd1);
    check_eq("wd_sticky", 32'(to_a), 32'd1);
`endif

    // Randomized traffic on both instances.
    resp_rand = 1;
    for (int k = 0; k < 1500; k++) begin
      pulse_v[0] = ($urandom_range(0, 3) == 0);
      pulse_v[1] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin ack_v[i] = 0; resp_last[i] = 0; resp_cnt[i] = 0; end
      end
      tick();
      rst = 1'b0;
    end
    pulse_v[0] = 0; pulse_v[1] = 0;
    wait_idle(0, 400);
    wait_idle(1, 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pulse_hs_tx.md
Name: pulse_hs_tx

Overview:
- Source-side (initiator) end of a two-phase req/ack pulse handshake crossing a clock boundary.
- Counts local event pulses and issues one request toggle per pending event.
- Waits for the destination's acknowledge toggle, resynchronised locally, before issuing the next request.
- Guarantees no event loss at any pulse rate up to counter capacity; the responder side returns ack as a toggle.

Parameters:
- CNT_W, 4: width of the pending-event counter; capacity is 2^CNT_W-1 events.
- SYNC_STAGES, 2: flip-flop stages on the ack_toggle_async resynchroniser; minimum legal value is 2.
- TIMEOUT_CYC, 1024: watchdog limit in clk cycles; used only when the optional feature is compiled in.

Ports:
- clk  input  1  single clock
- rst  input  1  synchronous reset, active-high
- pulse_in  input  1  one event per cycle-high
- ack_toggle_async  input  1  acknowledge toggle from the destination domain; asynchronous to clk
- req_toggle  output  1  request toggle to the destination domain; registered, glitch-free
- pending  output  CNT_W  events accepted but not yet acknowledged, including the one in flight
- busy  output  1  high while in WAIT_ACK
- pulse_done  output  1  single-cycle strobe when an ack is accepted
- overflow  output  1  sticky; set when an event is dropped
- timeout  output  1  sticky watchdog flag

Behaviour:
- Reset, sampled at posedge clk: all outputs go to 0, state goes to IDLE, synchroniser flops go to 0, ack_seen goes to 0.
- Reset mid-handshake abandons the in-flight request. The peer must be reset as well.
- Ack resynchronisation: ack_toggle_async passes through SYNC_STAGES flops to give ack_sync.
- ack_edge = ack_sync XOR ack_seen. ack_seen <= ack_sync every cycle.
- Pending counter:
  - +1 on pulse_in.
  - -1 on ack accepted.
  - Both in the same cycle: value unchanged.
  - pulse_in while pending == 2^CNT_W-1 with no decrement that cycle: event dropped, count saturates, overflow <= 1. overflow clears only on rst.
- FSM, state IDLE:
  - If registered pending != 0, then req_toggle <= ~req_toggle and go to WAIT_ACK.
  - ack_edge in IDLE is spurious (for example, peer reset skew). It is ignored, with no count change and no pulse_done.
- FSM, state WAIT_ACK:
  - busy = 1.
  - On ack_edge: pending decrements, pulse_done <= 1 for one cycle, go to IDLE.
  - The next request can therefore toggle at the earliest one cycle after pulse_done.
- Latency:
  - pulse_in high at edge N gives pending = 1 after N, and req_toggle flips at edge N+1.
  - Ack flip gives pulse_done high after SYNC_STAGES+1 edges.
- Throughput: one event per (round-trip + 2) clk cycles.
- req_toggle changes only on an FSM IDLE->WAIT_ACK transition. It never changes twice without an intervening ack.

Optional Feature:
- Macro: PULSE_HS_TX_TIMEOUT_EN.
- When defined:
  - A watchdog counter of width $clog2(TIMEOUT_CYC+1) clears on entry to WAIT_ACK and increments each cycle in WAIT_ACK.
  - When it reaches TIMEOUT_CYC, timeout <= 1 (sticky until rst).
  - FSM stays in WAIT_ACK, with no retransmit.
- When undefined: no counter is built and timeout is tied to 0.

Decomposition:
- Shared package pulse_hs_pkg holds:
  - state encoding localparams ST_IDLE = 1'b0 and ST_WAIT_ACK = 1'b1;
  - the minimum SYNC_STAGES constant.
- The responder later reuses the same package.
- One sub-module, bit_sync: a SYNC_STAGES-deep single-bit synchroniser with ASYNC_REG attributes and synchronous reset to 0, instantiated for ack_toggle_async.

Test Plan:
- Single event: rst released, pulse_in for 1 cycle, bench acks 5 cycles after the req flip.
  - req_toggle 0->1 exactly one edge after pending = 1.
  - pulse_done fires SYNC_STAGES+1 edges after the ack flip.
  - pending returns to 0 and busy is low.
- Burst: pulse_in high 5 consecutive cycles, auto-responder with 3-cycle ack delay.
  - Exactly 5 req_toggle flips and 5 pulse_done strobes.
  - pending peaks at 5; no overflow.
- Overflow: CNT_W = 2, 4 pulses with ack withheld.
  - pending saturates at 3 and overflow = 1.
  - After 3 acks, pending = 0 and overflow stays 1 until rst.
- Simultaneous: pulse_in asserted in the same cycle the ack is accepted with pending = 2.
  - pending stays 2 and pulse_done = 1.
- Spurious/reset: toggle ack in IDLE with pending = 0.
  - No pulse_done and no req flip.
  - Assert rst during WAIT_ACK: all outputs 0 next cycle.
- Timeout (macro defined, TIMEOUT_CYC = 16): send a request and never ack.
  - timeout = 1 exactly 16 cycles after entering WAIT_ACK.
  - A late ack still completes normally.
